// File: rtl/scalar_wb_scoreboard_if.sv
// Issue/writeback/hazard bundle between the issue stage and the scalar write scoreboard.
interface scalar_wb_scoreboard_if #(
  parameter int CNT_W = 2
);
  logic [4:0]       iss_rs1;
  logic             iss_rs1_used;
  logic [4:0]       iss_rs2;
  logic             iss_rs2_used;
  logic [4:0]       iss_rd;
  logic             iss_rd_we;
  logic             iss_fire;
  logic             s_we;
  logic [4:0]       s_waddr;
  logic             err_clr;
  logic             hazard_raw;
  logic             hazard_waw;
  logic [31:0]      busy_mask;
  logic [CNT_W+4:0] outstanding;
  logic             idle;
  logic             err_underflow;
  logic             err_overflow;

  modport master (
    output iss_rs1, iss_rs1_used, iss_rs2, iss_rs2_used, iss_rd, iss_rd_we, iss_fire,
    output s_we, s_waddr, err_clr,
    input  hazard_raw, hazard_waw, busy_mask, outstanding, idle, err_underflow, err_overflow
  );

  modport slave (
    input  iss_rs1, iss_rs1_used, iss_rs2, iss_rs2_used, iss_rd, iss_rd_we, iss_fire,
    input  s_we, s_waddr, err_clr,
    output hazard_raw, hazard_waw, busy_mask, outstanding, idle, err_underflow, err_overflow
  );
endinterface

// File: rtl/scalar_wb_scoreboard.sv
// Per-register in-flight write counters; issue/commit visible next cycle, hazards combinational.
// No backpressure of its own: hazards are advisory to issue stall logic, counters saturate on misuse.
module scalar_wb_scoreboard #(
  parameter int CNT_W     = 2,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  scalar_wb_scoreboard_if.slave sb
);
  localparam int OW = CNT_W + 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt [32];
  logic [OW-1:0]    r_outstanding;
  logic             r_err_uf;
  logic             r_err_of;

  logic        w_inc;
  logic        w_dec;
  logic        w_same;
  logic        w_rd_full;
  logic        w_wa_empty;
  logic        w_inc_eff;
  logic        w_dec_eff;
  logic        w_new_of;
  logic        w_new_uf;
  logic        w_rs1_ready;
  logic        w_rs2_ready;
  logic [31:0] w_busy;

  assign w_inc      = sb.iss_fire && sb.iss_rd_we && (sb.iss_rd != 5'd0);
  assign w_dec      = sb.s_we && (sb.s_waddr != 5'd0);
  // Same-register issue+commit cancels out, so neither saturation nor underflow applies.
  assign w_same     = w_inc && w_dec && (sb.iss_rd == sb.s_waddr);
  assign w_rd_full  = (r_cnt[sb.iss_rd] == CNT_MAX);
  assign w_wa_empty = (r_cnt[sb.s_waddr] == '0);
  assign w_inc_eff  = w_inc && !w_same && !w_rd_full;
  assign w_dec_eff  = w_dec && !w_same && !w_wa_empty;
  assign w_new_of   = w_inc && !w_same && w_rd_full;
  assign w_new_uf   = w_dec && !w_same && w_wa_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_cnt[i] <= '0;
    end else begin
      if (w_inc_eff) r_cnt[sb.iss_rd]  <= r_cnt[sb.iss_rd] + CNT_W'(1);
      if (w_dec_eff) r_cnt[sb.s_waddr] <= r_cnt[sb.s_waddr] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_err_uf      <= 1'b0;
      r_err_of      <= 1'b0;
    end else begin
      r_outstanding <= r_outstanding + OW'(w_inc_eff) - OW'(w_dec_eff);
      r_err_uf      <= (r_err_uf && !sb.err_clr) || w_new_uf;
      r_err_of      <= (r_err_of && !sb.err_clr) || w_new_of;
    end
  end

  // A last outstanding write committing this cycle lands in the write-through regfile.
  assign w_rs1_ready = (r_cnt[sb.iss_rs1] == '0) ||
                       (WB_BYPASS && (r_cnt[sb.iss_rs1] == CNT_W'(1)) &&
                        sb.s_we && (sb.s_waddr == sb.iss_rs1));
  assign w_rs2_ready = (r_cnt[sb.iss_rs2] == '0) ||
                       (WB_BYPASS && (r_cnt[sb.iss_rs2] == CNT_W'(1)) &&
                        sb.s_we && (sb.s_waddr == sb.iss_rs2));

  assign sb.hazard_raw = (sb.iss_rs1_used && (sb.iss_rs1 != 5'd0) && !w_rs1_ready) ||
                         (sb.iss_rs2_used && (sb.iss_rs2 != 5'd0) && !w_rs2_ready);
  assign sb.hazard_waw = sb.iss_rd_we && (sb.iss_rd != 5'd0) && w_rd_full &&
                         !(w_dec && (sb.s_waddr == sb.iss_rd));

  always_comb begin
    w_busy = '0;
    for (int i = 1; i < 32; i++) w_busy[i] = (r_cnt[i] != '0);
  end

  assign sb.busy_mask     = w_busy;
  assign sb.outstanding   = r_outstanding;
  assign sb.idle          = (r_outstanding == '0);
  assign sb.err_underflow = r_err_uf;
  assign sb.err_overflow  = r_err_of;
endmodule

// File: doc/scalar_wb_scoreboard.md
Name: scalar_wb_scoreboard

Overview:
- Per-register in-flight write tracker for the scalar register file.
- Issue stage marks a destination busy when an instruction with a scalar rd is accepted.
- The scalar writeback arbiter's selected commit (s_we/s_waddr) retires it.
- Outputs RAW/WAW hazards to the issue stall logic. Per-register counters allow multiple outstanding writes to the same rd from units of different latency (LSU, FP, VALU, ALU).

Parameters:
- CNT_W, 2: per-register counter width; max outstanding writes per register = 2^CNT_W - 1.
- WB_BYPASS, 1: when 1, a register whose last outstanding write commits this cycle is reported ready this cycle (regfile is write-through).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- iss_rs1  in  5  source 1 of instruction at issue
- iss_rs1_used  in  1  rs1 is read
- iss_rs2  in  5  source 2
- iss_rs2_used  in  1  rs2 is read
- iss_rd  in  5  destination
- iss_rd_we  in  1  instruction writes a scalar rd
- iss_fire  in  1  instruction accepted by issue this cycle
- s_we  in  1  scalar writeback commit from arbiter
- s_waddr  in  5  committed register
- err_clr  in  1  clears sticky error flags
- hazard_raw  out  1  rs1/rs2 has an outstanding write
- hazard_waw  out  1  rd counter saturated (cannot accept another write)
- busy_mask  out  32  bit i = count[i] != 0 (registered view)
- outstanding  out  CNT_W+5  total in-flight writes across all registers
- idle  out  1  outstanding == 0
- err_underflow  out  1  sticky: commit to a register with count 0
- err_overflow  out  1  sticky: issue to a saturated register

Behaviour:
- Reset (async, rst_n=0):
  - all counts = 0, outstanding = 0.
  - busy_mask = 0, idle = 1, hazards = 0, error flags = 0.
  - Reset mid-operation discards all tracking; later commits for pre-reset issues set err_underflow.
- Register x0:
  - Never tracked; its count stays 0.
  - Issue or commit targeting x0 has no effect and never raises an error.
  - rs == 0 never causes a RAW hazard.
- Increment: inc = iss_fire && iss_rd_we && iss_rd != 0.
- Decrement: dec = s_we && s_waddr != 0.
- Counter update per register r, next edge:
  - inc to r only: count+1.
  - dec to r only: count-1.
  - inc and dec to same r in same cycle: count unchanged; no error, even if count is 0 or saturated.
  - dec with count 0 (no same-cycle inc): count stays 0; err_underflow <= 1.
  - inc with count == max (no same-cycle dec): count stays max; err_overflow <= 1.
- outstanding:
  - Tracks the sum of counts: +1 on effective inc, -1 on effective dec, net 0 when both.
  - Never wraps.
- Latency:
  - Issue in cycle N is visible in busy_mask and hazards from cycle N+1.
  - Commit in cycle N clears the count at N+1.
- hazard_raw (combinational from current counts):
  - (rs1_used && rs1 != 0 && ready(rs1) == 0) || same for rs2.
  - ready(r) = count[r] == 0, or (WB_BYPASS && count[r] == 1 && s_we && s_waddr == r).
- hazard_waw (combinational): iss_rd_we && iss_rd != 0 && count[iss_rd] == max, unless a same-cycle dec targets iss_rd.
- Hazard outputs do not depend on iss_fire. Asserting iss_fire while a hazard is high is a protocol error: the counter still follows the update rules above.
- err_clr:
  - Clears both sticky flags next edge.
  - Same-cycle new error wins (flag stays 1).
- Purely sequential counters plus combinational hazard decode; no internal FSM beyond the counters.

Test Plan:
- Reset, then issue rd=5 (fire) at cycle 0 -> busy_mask[5]=1, outstanding=1, idle=0 at cycle 1. Commit s_waddr=5 at cycle 3 -> busy_mask=0, idle=1 at cycle 4.
- Three issues to rd=7 with CNT_W=2 -> count 3, hazard_waw=1 for a 4th. Fire it anyway -> count stays 3, err_overflow=1. err_clr -> 0 next cycle.
- count[9]=1, commit 9 while issue reads rs1=9:
  - WB_BYPASS=1 -> hazard_raw=0.
  - WB_BYPASS=0 -> hazard_raw=1.
- Same-cycle issue rd=4 and commit 4 with count[4]=1 -> count stays 1, outstanding unchanged, no error.
- Commit to rd=12 with count 0 -> err_underflow=1, outstanding stays 0. Issue/commit to x0 and rs1=0 reads -> no state change, hazard_raw=0.
- Async reset asserted with outstanding=6 -> all outputs at reset values immediately. Post-reset commit to a previously busy register -> err_underflow=1.
